// File: rtl/led_fade_sequencer_pkg.sv
// Shared types and helpers for the RGB LED fade sequencer: FSM states,
// command layout and the per-channel brightness step.
package led_pkg;

  localparam int LED_DIV_W = 16;
  localparam int CMD_W     = 24 + 2 * LED_DIV_W;

  // Encoding 2'b11 is never entered; the FSM falls back to IDLE from it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FADE = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic [23:0]          rgb;
    logic [LED_DIV_W-1:0] step_div;
    logic [LED_DIV_W-1:0] hold;
  } cmd_t;

  // Moves one unsigned 8-bit channel a single count toward its target, so it never wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

endpackage

// File: rtl/led_fade_sequencer_if.sv
// Command port of the fade sequencer: the host is the master, the sequencer the slave.
// Handshake: a command transfers on any clock edge where cmd_valid && cmd_ready; the master
// holds cmd_valid and the payload stable until that edge, and ready may drop at any time.
interface led_fade_sequencer_if #(
  parameter int DIV_W = 16
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_rgb;
  logic [DIV_W-1:0] cmd_step_div;
  logic [DIV_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_rgb, cmd_step_div, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rgb, cmd_step_div, cmd_hold,
    output cmd_ready
  );

endinterface

// File: rtl/led_fade_sequencer_cmd_fifo.sv
// Synchronous command FIFO with a flush input; head shows the oldest entry
// whenever the FIFO is not empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 56
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// Queues colour-fade commands and ramps three 8-bit brightness channels toward
// each target one count per step, then holds the colour before the next command.
module led_fade_sequencer
  import led_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = LED_DIV_W
) (
  input  logic                clk,
  input  logic                reset_n,
  led_fade_sequencer_if.slave cmd,
  input  logic                abort,
  output logic [7:0]          bright_r,
  output logic [7:0]          bright_g,
  output logic [7:0]          bright_b,
  output logic                busy,
  output logic                done,
  output state_e              dbg_state
);

  localparam int CW = 24 + 2 * DIV_W;

  state_e           state_q, state_d;
  logic [23:0]      rgb_q, rgb_d;
  logic [23:0]      target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hold_q, hold_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0] hcnt_q, hcnt_d;
  logic             ready_en_q;

  logic             fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]    fifo_head, fifo_wdata;
  logic             at_target, step_now, hold_last;

  // ready_en_q keeps the port closed while in reset and opens it one edge after release.
  assign cmd.cmd_ready = ready_en_q && !fifo_full && !abort;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign fifo_wdata    = {cmd.cmd_rgb, cmd.cmd_step_div, cmd.cmd_hold};

  assign at_target = (rgb_q == target_q);
  assign step_now  = (tick_q == div_q);
  assign hold_last = (hcnt_q == hold_q);

  assign bright_r  = rgb_q[23:16];
  assign bright_g  = rgb_q[15:8];
  assign bright_b  = rgb_q[7:0];
  assign dbg_state = state_q;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) state_d = ST_FADE;
        ST_FADE: if (at_target)   state_d = ST_HOLD;
        ST_HOLD: if (hold_last)   state_d = ST_IDLE;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pop  = (state_q == ST_IDLE) && !fifo_empty && !abort;
    done = (state_q == ST_HOLD) && hold_last && !abort;
    busy = (state_q != ST_IDLE) || !fifo_empty;
  end

  // Datapath: latch the command on pop, prescale fade steps, count hold clocks.
  always_comb begin
    rgb_d    = rgb_q;
    target_d = target_q;
    div_d    = div_q;
    hold_d   = hold_q;
    tick_d   = tick_q;
    hcnt_d   = hcnt_q;
    if (abort) begin
      tick_d = '0;
      hcnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            target_d = fifo_head[CW-1 -: 24];
            div_d    = fifo_head[2*DIV_W-1 -: DIV_W];
            hold_d   = fifo_head[DIV_W-1:0];
            tick_d   = '0;
            hcnt_d   = '0;
          end
        end
        ST_FADE: begin
          if (!at_target) begin
            if (step_now) begin
              tick_d = '0;
              rgb_d  = {step_toward(rgb_q[23:16], target_q[23:16]),
                        step_toward(rgb_q[15:8],  target_q[15:8]),
                        step_toward(rgb_q[7:0],   target_q[7:0])};
            end else begin
              tick_d = tick_q + DIV_W'(1);
            end
          end
        end
        ST_HOLD: hcnt_d = hold_last ? '0 : hcnt_q + DIV_W'(1);
        default: begin
          tick_d = '0;
          hcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q      <= '0;
      target_q   <= '0;
      div_q      <= '0;
      hold_q     <= '0;
      tick_q     <= '0;
      hcnt_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      rgb_q      <= rgb_d;
      target_q   <= target_d;
      div_q      <= div_d;
      hold_q     <= hold_d;
      tick_q     <= tick_d;
      hcnt_q     <= hcnt_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Self-checking bench for led_fade_sequencer: a table of single-command fades
// from reset plus hand-written sequences for latency, queueing, abort and reset.
module tb_led_fade_sequencer;
  import led_pkg::*;

  localparam int DIV_W = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] bright_r, bright_g, bright_b;
  logic       busy, done;
  state_e     dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  logic [23:0] exp_q[$];

  typedef struct {
    logic [23:0]      rgb;
    logic [DIV_W-1:0] step_div;
    logic [DIV_W-1:0] hold;
    int               exp_edges;
  } vec_t;
  vec_t vecs[6];

  led_fade_sequencer_if #(.DIV_W(DIV_W)) cmd_if ();

  led_fade_sequencer #(
    .FIFO_DEPTH (4),
    .DIV_W      (DIV_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cmd_if.slave),
    .abort     (abort),
    .bright_r  (bright_r),
    .bright_g  (bright_g),
    .bright_b  (bright_b),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drivers
  task automatic do_reset();
    reset_n = 1'b0;
    abort   = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic push_cmd(input logic [23:0] rgb, input logic [DIV_W-1:0] sdiv,
                          input logic [DIV_W-1:0] hold);
    bit accepted = 1'b0;
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_rgb      = rgb;
    cmd_if.cmd_step_div = sdiv;
    cmd_if.cmd_hold     = hold;
    for (int i = 0; i < 2000; i++) begin
      if (cmd_if.cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("push_accept", 32'(accepted), 32'd1);
    if (accepted) begin
      @(posedge clk);
      exp_q.push_back(rgb);
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    int dn;
    logic [23:0] e;

    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_rgb      = '0;
    cmd_if.cmd_step_div = '0;
    cmd_if.cmd_hold     = '0;

    // Edges from acceptance to the done sample: 2 + (step_div+1)*max|delta| + hold.
    vecs[0] = '{24'hFF0080, 16'd0, 16'd3, 260};
    vecs[1] = '{24'h000004, 16'd3, 16'd0, 18};
    vecs[2] = '{24'h000000, 16'd0, 16'd0, 2};
    vecs[3] = '{24'h0A1402, 16'd1, 16'd5, 47};
    vecs[4] = '{24'h030303, 16'd2, 16'd1, 12};
    vecs[5] = '{24'h808080, 16'd0, 16'd0, 130};

    // Reset state, including ready held low until one edge after release
    #2;
    check("rst_bright", 32'({bright_r, bright_g, bright_b}), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(cmd_if.cmd_ready), 32'd1);

    // Table of single fades from reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      @(negedge clk);
      push_cmd(vecs[v].rgb, vecs[v].step_div, vecs[v].hold);
      @(negedge clk);
      check($sformatf("v%0d_first_fade", v), 32'(dbg_state), 32'(ST_FADE));
      k = 1;
      dn = 0;
      while (!done && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("v%0d_done_edge", v), 32'(k), 32'(vecs[v].exp_edges));
      check($sformatf("v%0d_colour", v), 32'({bright_r, bright_g, bright_b}), 32'(vecs[v].rgb));
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", v), 32'(done), 32'd0);
      check($sformatf("v%0d_busy_low", v), 32'(busy), 32'd0);
    end

    // Latency and per-channel progress for FF_00_80, step_div=0
    do_reset();
    @(negedge clk);
    push_cmd(24'hFF0080, 16'd0, 16'd3);
    check("lat_idle_n", 32'(dbg_state), 32'(ST_IDLE));
    check("lat_busy_n", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_fade_n1", 32'(dbg_state), 32'(ST_FADE));
    check("lat_r_n1", 32'(bright_r), 32'd0);
    repeat (128) @(negedge clk);
    check("b_reach_128", 32'(bright_b), 32'd128);
    check("r_at_128", 32'(bright_r), 32'd128);
    repeat (127) @(negedge clk);
    check("r_reach_255", 32'(bright_r), 32'd255);
    check("b_stays_128", 32'(bright_b), 32'd128);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (i == 3) check("done_after_4_hold", 32'(done), 32'd1);
      if (i == 4) check("busy_fall", 32'(busy), 32'd0);
    end
    check("done_pulse_count", 32'(dn), 32'd1);

    // step_div=3: blue increments once every 4 clocks
    do_reset();
    @(negedge clk);
    push_cmd(24'h000004, 16'd3, 16'd0);
    @(negedge clk);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check($sformatf("div3_b_t%0d", j), 32'(bright_b), 32'(j / 4));
    end

    // Five commands behind a long fade: queue fills, all run in order
    do_reset();
    @(negedge clk);
    dn = 0;
    fork
      begin
        for (int i = 0; i < 3000 && dn < 6; i++) begin
          @(negedge clk);
          if (done) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
            check($sformatf("order_%0d", dn), 32'({bright_r, bright_g, bright_b}), 32'(e));
            dn++;
          end
        end
      end
      begin
        push_cmd(24'h400000, 16'd0, 16'd0);
        push_cmd(24'h000010, 16'd0, 16'd0);
        push_cmd(24'h101010, 16'd0, 16'd0);
        push_cmd(24'h200000, 16'd0, 16'd0);
        push_cmd(24'h000000, 16'd0, 16'd0);
        cmd_if.cmd_valid = 1'b1;
        check("full_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
        push_cmd(24'h050505, 16'd0, 16'd0);
      end
    join
    check("done_count", 32'(dn), 32'd6);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Abort mid-fade at bright_r=100 with two commands queued
    do_reset();
    @(negedge clk);
    push_cmd(24'hFF0000, 16'd0, 16'd0);
    push_cmd(24'h00FF00, 16'd0, 16'd0);
    push_cmd(24'h0000FF, 16'd0, 16'd0);
    k = 0;
    while (bright_r != 8'd100 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_100", 32'(bright_r), 32'd100);
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_rgb   = 24'h123456;
    #1 check("abort_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_r_frozen", 32'(bright_r), 32'd100);
    check("abort_busy", 32'(busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_r_still", 32'(bright_r), 32'd100);
    check("abort_fifo_empty", 32'(busy), 32'd0);
    push_cmd(24'h620000, 16'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    check("post_abort_r99", 32'(bright_r), 32'd99);
    @(negedge clk);
    check("post_abort_r98", 32'(bright_r), 32'd98);
    @(negedge clk);
    check("post_abort_done", 32'(done), 32'd1);

    // Asynchronous reset in the middle of HOLD
    do_reset();
    @(negedge clk);
    push_cmd(24'h0A0A0A, 16'd0, 16'd20);
    k = 0;
    while (dbg_state != ST_HOLD && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reach_hold", 32'(dbg_state), 32'(ST_HOLD));
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_bright", 32'({bright_r, bright_g, bright_b}), 32'h0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_fade_sequencer.md
Name: led_fade_sequencer

Overview:
- Command-driven scheduler that sequences the three PWM brightness channels of the RGB LED.
- Queues colour-fade commands and ramps each channel's 8-bit brightness toward its target at a programmable step rate.
- Holds the final colour for a programmable time, then starts the next queued command.
- Sits between a host/pattern source and the three pwm instances; output polarity (LED pins active-low) stays inside pwm.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of two, >=2)
- DIV_W, 16, width of step-divider and hold counters

Ports:
- clk  in  1  system clock (48 MHz HFOSC)
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_rgb  in  24  target brightness {r[23:16], g[15:8], b[7:0]}
- cmd_step_div  in  DIV_W  clocks per brightness step minus 1
- cmd_hold  in  DIV_W  clocks to hold target after fade completes
- abort  in  1  flush queue, freeze colour, return to IDLE
- bright_r / bright_g / bright_b  out  8 each  current brightness to pwm
- busy  out  1  state!=IDLE or queue non-empty
- done  out  1  one-cycle pulse when a command's hold completes

Behaviour:
- Reset (async assert, sync release): bright_* = 0, state IDLE, FIFO empty, counters 0, done 0, busy 0; cmd_ready rises the first cycle after release.
- cmd_ready = !fifo_full && !abort. Push happens on valid&&ready. Full FIFO: ready low, no overwrite.
- IDLE, FIFO non-empty: pop head and latch target_rgb, step_div, hold; next cycle is FADE with tick counter = 0.
- Command latency: accepted at edge N -> popped at N+1 -> first FADE cycle N+2, provided IDLE and FIFO was empty.
- FADE: tick counts 0..step_div. On the cycle tick==step_div, tick resets to 0 and each channel independently moves +1 or -1 toward its target; a channel at target does not move.
- FADE exit: when all three channels equal target, go to HOLD on the next cycle. Applies immediately if the command's target equals the current colour; at most 1 FADE cycle is spent.
- step_div=0 means one step per clock. Fade time = max|delta| × (step_div+1) clocks.
- Arithmetic: unsigned 8-bit. Because steps are ±1 toward target, no wrap can occur. A fade 0->255 reaches 255 and stops.
- HOLD: counts hold clocks. hold=0 means 1 HOLD cycle. On the final HOLD cycle assert done for 1 cycle, then go to IDLE.
- Back-to-back commands: IDLE pops the next entry the cycle after done, with no extra gap.
- Simultaneous push and pop on a full FIFO: not possible, because ready is low while full.
- Simultaneous push and pop on a non-full FIFO: both occur and occupancy is unchanged.
- abort (any state): next edge empties the FIFO, sets state IDLE, clears counters, and suppresses done; bright_* keep their current values.
- A push presented in the abort cycle is not accepted (ready low).
- Reset mid-fade: immediately forces all outputs to reset values.
- States: IDLE(00), FADE(01), HOLD(10); encoding 11 is unreachable and recovers to IDLE.

Decomposition:
- Shared package led_pkg holds:
  - state enum IDLE/FADE/HOLD
  - command struct {rgb[23:0], step_div, hold}
  - CMD_W = 24+2*DIV_W
- One sub-module, cmd_fifo: synchronous FIFO with parameters DEPTH and WIDTH, async active-low reset, and push/pop/full/empty/head.
- The FSM, prescaler and per-channel step logic stay in led_fade_sequencer; the step logic is a small function in led_pkg.

Test Plan:
- Reset then push {rgb=FF_00_80, step_div=0, hold=3} at edge N -> first FADE at N+2; bright_r reaches 255 after 255 steps and bright_b reaches 128 after 128 steps; done pulses once, 4 HOLD cycles after the last step; busy falls the next cycle.
- step_div=3, target 00_00_04 from 00_00_00 -> bright_b increments exactly every 4 clocks: 1,2,3,4 over 16 clocks.
- Push 5 commands back-to-back with FIFO_DEPTH=4 during a long fade -> cmd_ready low once 4 are queued; all accepted commands execute in order; done count equals accepted count.
- Target equal to current colour (00_00_00 from reset), hold=0 -> FADE lasts 1 cycle, HOLD 1 cycle, then done.
- abort mid-fade at bright_r=100 with 2 queued -> IDLE next cycle; bright_r stays 100; FIFO empty; no done; new command accepted afterwards and fades from 100.
- Assert reset_n low mid-HOLD, asynchronously between edges -> bright_* = 0, busy = 0 and done = 0 immediately, without waiting for a clock edge.
